// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification helpers for alu_mc.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_MUL  = 5'b00010;
   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_REM  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_XOR  = 5'b00111;
   localparam logic [4:0] OP_NAND = 5'b01000;
   localparam logic [4:0] OP_NOR  = 5'b01001;
   localparam logic [4:0] OP_XNOR = 5'b01010;
   localparam logic [4:0] OP_NOT  = 5'b01011;
   localparam logic [4:0] OP_NEG  = 5'b01100;
   localparam logic [4:0] OP_SLL  = 5'b01101;
   localparam logic [4:0] OP_SRL  = 5'b01110;
   localparam logic [4:0] OP_SRA  = 5'b01111;
   localparam logic [4:0] OP_SLT  = 5'b10000;
   localparam logic [4:0] OP_SLTU = 5'b10001;
   localparam logic [4:0] OP_INC  = 5'b10010;
   localparam logic [4:0] OP_DEC  = 5'b10011;
   localparam logic [4:0] OP_ROL  = 5'b10100;
   localparam logic [4:0] OP_ROR  = 5'b10101;
   localparam logic [4:0] OP_PASA = 5'b10110;
   localparam logic [4:0] OP_PASB = 5'b10111;
   localparam logic [4:0] OP_MULH = 5'b11000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic is_iterative(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one WIDTH+1-bit adder.
// The first step is taken on the start edge, so WIDTH steps finish WIDTH-1 cycles later.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       opcode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;

   // {hi, lo}: product register for multiply, {remainder, dividend/quotient} for divide
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
   logic             div_q, div_d, sel_hi_q, sel_hi_d, busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] hi_s, lo_s, mc_s, hi_n, lo_n;
   logic             dv_s, add_cin;
   logic [WIDTH:0]   r_sh, add_x, add_y, sum;

   always_comb begin
      hi_s = start ? '0 : hi_q;
      lo_s = start ? a : lo_q;
      mc_s = start ? b : mcand_q;
      dv_s = start ? is_div_op(opcode) : div_q;
      r_sh = {hi_s, lo_s[WIDTH-1]};
      if (dv_s) begin
         add_x   = r_sh;
         add_y   = ~{1'b0, mc_s};
         add_cin = 1'b1;
      end else begin
         add_x   = {1'b0, hi_s};
         add_y   = lo_s[0] ? {1'b0, mc_s} : '0;
         add_cin = 1'b0;
      end
      sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
      if (dv_s) begin
         // remainder < divisor keeps r_sh < 2*divisor, so sum[WIDTH] is the borrow
         hi_n = sum[WIDTH] ? r_sh[WIDTH-1:0] : sum[WIDTH-1:0];
         lo_n = {lo_s[WIDTH-2:0], ~sum[WIDTH]};
      end else begin
         hi_n = sum[WIDTH:1];
         lo_n = {sum[0], lo_s[WIDTH-1:1]};
      end
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      div_d    = div_q;
      sel_hi_d = sel_hi_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      if (start) begin
         mcand_d  = b;
         div_d    = is_div_op(opcode);
         sel_hi_d = (opcode == OP_MULH) || (opcode == OP_REM);
         busy_d   = 1'b1;
         cnt_d    = CW'(WIDTH);
      end else if (busy_q) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(2)) busy_d = 1'b0;
      end
      if (start || busy_q) begin
         hi_d = hi_n;
         lo_d = lo_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         div_q    <= 1'b0;
         sel_hi_q <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         div_q    <= div_d;
         sel_hi_q <= sel_hi_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy   = busy_q;
   assign done   = busy_q && (cnt_q == CW'(2));
   assign result = sel_hi_q ? hi_q : lo_q;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle ops register in one cycle, MUL/MULH/DIV/REM
// go through the iterative unit and complete WIDTH+1 cycles after acceptance.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry_out,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int SHW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d, zero_q, zero_d, neg_q, neg_d;
   logic             carry_q, carry_d, ovf_q, ovf_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             accept, start, it_busy, it_done;
   logic [WIDTH-1:0] it_result, alu_res;
   logic             alu_c, alu_v, alu_dbz;
   logic [SHW-1:0]   sh, rot_amt;
   logic [2*WIDTH-1:0] rot_w;
   logic [WIDTH:0]   sum_w;

   assign in_ready = (state_q == S_IDLE) && !it_busy && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign sh       = b[SHW-1:0];
   // Right-rotating {a,a}: low half is ROR (ROL uses the negated amount), high half is SRL
   assign rot_amt  = (opcode == OP_ROL) ? -sh : sh;
   assign rot_w    = {a, a} >> rot_amt;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_dbz = 1'b0;
      sum_w   = '0;
      case (opcode)
         OP_ADD: begin
            sum_w   = {1'b0, a} + {1'b0, b};
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum_w   = {1'b0, a} - {1'b0, b};
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_INC: begin
            sum_w   = {1'b0, a} + (WIDTH+1)'(1);
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
         end
         OP_DEC: begin
            sum_w   = {1'b0, a} - (WIDTH+1)'(1);
            alu_res = sum_w[WIDTH-1:0];
            alu_c   = sum_w[WIDTH];
         end
         // Only the b == 0 case of DIV/REM is ever loaded from this path
         OP_DIV, OP_REM: alu_dbz = 1'b1;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NAND: alu_res = ~(a & b);
         OP_NOR:  alu_res = ~(a | b);
         OP_XNOR: alu_res = ~(a ^ b);
         OP_NOT:  alu_res = ~a;
         OP_NEG:  alu_res = '0 - a;
         OP_SLL:  alu_res = a << sh;
         OP_SRL:  alu_res = rot_w[2*WIDTH-1:WIDTH];
         OP_SRA:  alu_res = $signed(a) >>> sh;
         OP_SLT:  alu_res = ($signed(a) < $signed(b)) ? '1 : '0;
         OP_SLTU: alu_res = (a < b) ? '1 : '0;
         OP_ROL, OP_ROR: alu_res = rot_w[WIDTH-1:0];
         OP_PASA: alu_res = a;
         OP_PASB: alu_res = b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      result_d    = result_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      dbz_d       = dbz_q;
      start       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_iterative(opcode) && !(is_div_op(opcode) && (b == '0))) begin
                  start   = 1'b1;
                  state_d = S_ITER;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  carry_d     = alu_c;
                  ovf_d       = alu_v;
                  dbz_d       = alu_dbz;
               end
            end
         end
         S_ITER: if (it_done) state_d = S_DONE;
         S_DONE: begin
            out_valid_d = 1'b1;
            result_d    = it_result;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
      end
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .busy   (it_busy),
      .done   (it_done),
      .result (it_result)
   );

   assign out_valid   = out_valid_q;
   assign result      = result_q;
   assign zero        = zero_q;
   assign negative    = neg_q;
   assign carry_out   = carry_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results queued at issue, compared when out_valid appears.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [4:0]  opcode = '0;
   logic        in_ready, out_valid, zero, negative, carry_out, overflow, div_by_zero;
   logic [15:0] result;

   typedef struct {
      logic [15:0] res;
      logic        c, v, dbz;
   } exp_t;
   exp_t sb[$];

   int total = 0, bad = 0;

   alu_mc #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry_out(carry_out),
      .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] res, input logic c, input logic v, input logic dbz);
      exp_t e;
      e.res = res; e.c = c; e.v = v; e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Compare the current output stage against the oldest queued expectation
   task automatic check_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL %s observed=output expected=empty_scoreboard", tag);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".valid"}, out_valid, 1);
      chk({tag, ".result"}, result, e.res);
      chk({tag, ".zero"}, zero, (e.res == 16'h0));
      chk({tag, ".neg"}, negative, e.res[15]);
      chk({tag, ".carry"}, carry_out, e.c);
      chk({tag, ".ovf"}, overflow, e.v);
      chk({tag, ".dbz"}, div_by_zero, e.dbz);
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [15:0] ai,
                         input logic [15:0] bi, input logic [15:0] res, input logic c,
                         input logic v, input logic dbz, input int lat);
      int n;
      push(res, c, v, dbz);
      @(negedge clk);
      opcode = op; a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, ".in_ready"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin
         chk({tag, ".busy_in_ready"}, in_ready, 0);
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, n, lat);
      check_out(tag);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [31:0] prod;
      int saw;

      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.result", result, 0);
      chk("rst.zero", zero, 0);
      chk("rst.flags", {negative, carry_out, overflow, div_by_zero}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1);
      run_op("mul",  OP_MUL,  16'h1234, 16'h0100, 16'h3400, 0, 0, 0, 17);
      run_op("mulh", OP_MULH, 16'h1234, 16'h0100, 16'h0012, 0, 0, 0, 17);
      run_op("div",  OP_DIV,  16'd100, 16'd7, 16'd14, 0, 0, 0, 17);
      run_op("rem",  OP_REM,  16'd100, 16'd7, 16'd2, 0, 0, 0, 17);
      run_op("div0", OP_DIV,  16'd5, 16'd0, 16'd0, 0, 0, 1, 1);
      run_op("rem0", OP_REM,  16'd9, 16'd0, 16'd0, 0, 0, 1, 1);
      run_op("rol0", OP_ROL,  16'h8001, 16'h0000, 16'h8001, 0, 0, 0, 1);
      run_op("rol1", OP_ROL,  16'h8001, 16'h0001, 16'h0003, 0, 0, 0, 1);
      run_op("ror1", OP_ROR,  16'h8001, 16'h0011, 16'hC000, 0, 0, 0, 1);
      run_op("sra15", OP_SRA, 16'h8000, 16'd15, 16'hFFFF, 0, 0, 0, 1);
      run_op("srl4", OP_SRL,  16'h8421, 16'd4, 16'h0842, 0, 0, 0, 1);
      run_op("sll4", OP_SLL,  16'h8421, 16'd4, 16'h4210, 0, 0, 0, 1);
      run_op("slt",  OP_SLT,  16'h8000, 16'h0001, 16'hFFFF, 0, 0, 0, 1);
      run_op("sltu", OP_SLTU, 16'h8000, 16'h0001, 16'h0000, 0, 0, 0, 1);
      run_op("inc",  OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 1);
      run_op("dec",  OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 1, 0, 0, 1);
      run_op("sub_eq", OP_SUB, 16'h0005, 16'h0005, 16'h0000, 0, 0, 0, 1);
      run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 1);
      run_op("add_c", OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1, 0, 0, 1);
      run_op("nand", OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF, 0, 0, 0, 1);
      run_op("neg",  OP_NEG,  16'h0001, 16'h0000, 16'hFFFF, 0, 0, 0, 1);
      run_op("pasb", OP_PASB, 16'h1111, 16'hA5A5, 16'hA5A5, 0, 0, 0, 1);
      run_op("undef", 5'b11111, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 1);

      for (int i = 0; i < 3; i++) begin
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(1, 65535));
         prod = {16'h0, ra} * {16'h0, rb};
         run_op("rmul",  OP_MUL,  ra, rb, prod[15:0], 0, 0, 0, 17);
         run_op("rmulh", OP_MULH, ra, rb, prod[31:16], 0, 0, 0, 17);
         run_op("rdiv",  OP_DIV,  ra, rb, ra / rb, 0, 0, 0, 17);
         run_op("rrem",  OP_REM,  ra, rb, ra % rb, 0, 0, 0, 17);
      end

      // backpressure: SUB result held for 5 cycles, then drain and accept together
      push(16'hFFFF, 1, 0, 0);
      @(negedge clk);
      opcode = OP_SUB; a = 16'h0000; b = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp.hold_valid", out_valid, 1);
         chk("bp.hold_result", result, 16'hFFFF);
         chk("bp.hold_carry", carry_out, 1);
         chk("bp.in_ready", in_ready, 0);
         @(negedge clk);
      end
      push(16'h0005, 0, 0, 0);
      opcode = OP_ADD; a = 16'h0002; b = 16'h0003; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("bp.both_ready", in_ready, 1);
      check_out("bp.sub");
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("bp.add");

      // reset 5 cycles into a DIV: nothing comes out afterwards
      @(negedge clk);
      opcode = OP_DIV; a = 16'd100; b = 16'd7; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst.out_valid", out_valid, 0);
      chk("mid_rst.in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("post_rst.in_ready", in_ready, 1);
      saw = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid) saw = 1;
      end
      chk("post_rst.no_stale", saw, 0);
      run_op("post_rst.add", OP_ADD, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 1);
      chk("sb.empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
